mhd_pattern_gen: RTL and testbench
==================================

Name: mhd_pattern_gen

Overview:
Sequential stimulus generator for the approximate-circuit miter flow, acting as the source side of the Hamming-distance check. Given a base word and a target distance k, it emits every WIDTH-bit word whose Hamming distance from the base is exactly k, one word per handshake, with masks in ascending numeric order. Benches and the error-injection harness use it to drive a known-distance pair (base, out_word) into the miter.

Parameters:
WIDTH, 8, word width in bits (1..16)
KW, 4, width of the k input; must satisfy 2^KW > WIDTH
CW, WIDTH+1, width of the emitted-word counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin enumeration; ignored unless idle
base  input  WIDTH  reference word; sampled on accepted start
k  input  KW  target Hamming distance; sampled on accepted start
out_ready  input  1  consumer ready
out_valid  output  1  out_word/out_mask valid
out_word  output  WIDTH  base_q XOR out_mask
out_mask  output  WIDTH  flipped-bit mask; popcount == k_q
busy  output  1  enumeration in progress
done  output  1  one-cycle pulse at end of enumeration
count  output  CW  words accepted in the current or last run

Behaviour:
- Reset (async assert, sync deassert used by integrator): state=IDLE; out_valid=0, out_word=0, out_mask=0, busy=0, done=0, count=0, cand=0.
- All outputs registered. States: IDLE, SCAN, HOLD, FIN.
- IDLE: busy=0. start=1 → latch base_q, k_q, cand=0, count=0, state=SCAN. If k>WIDTH → state=FIN directly (count stays 0, no words).
- SCAN (busy=1): evaluate cand once per cycle. popcount(cand)==k_q → out_mask<=cand, out_word<=base_q^cand, out_valid<=1, state=HOLD. Otherwise cand==all-ones → FIN; else cand<=cand+1.
- HOLD (busy=1, out_valid=1): out_word/out_mask stable until out_ready. On out_valid&&out_ready: count<=count+1, out_valid<=0; cand==all-ones → FIN, else cand<=cand+1, SCAN.
- FIN: done=1 for exactly one cycle, busy=0, state=IDLE next. count holds until next accepted start.
- Latency: first out_valid no earlier than 2 cycles after start (k=0: exactly 2). Consecutive words separated by ≥1 SCAN cycle.
- start while busy or in FIN: ignored, no effect on latched base_q/k_q.
- cand is WIDTH bits; all-ones test prevents wrap; no mask is emitted twice.
- Total words per run = C(WIDTH,k_q); count never exceeds 2^WIDTH−1 for k≤WIDTH.
- Reset mid-run: immediate return to reset values; no done pulse.

Optional Feature:
MHD_GEN_ABORT_EN: adds input abort (1 bit). When defined, abort=1 in SCAN or HOLD drops out_valid next cycle, goes to FIN (done pulses once), count keeps words accepted so far; abort in IDLE/FIN ignored; abort beats a simultaneous handshake (that word is not counted). Undefined: port absent, run always completes.

Decomposition:
- Package mhd_pkg: state enum type (IDLE, SCAN, HOLD, FIN), default WIDTH constant, popcount function.
- One sub-module natural: mhd_popcount (combinational WIDTH-bit popcount, output $clog2(WIDTH+1) bits), reusable by the miter side.

Test Plan:
- base=0x00, k=2, out_ready=1 → 28 words, first mask 0x03, second 0x05, last 0xC0; done pulse; count=28.
- base=0xA5, k=0 → exactly one word 0xA5 two cycles after start; count=1. k=8 → one word 0x5A, mask 0xFF.
- k=9 → no out_valid, done one cycle after start window, count=0.
- base=0x0F, k=1, out_ready toggled randomly → 8 words in mask order 0x01..0x80, out_word stable while stalled, no drops/duplicates.
- start pulsed with base=0xFF mid-run of base=0x00,k=3 → ignored, all 56 words XOR 0x00; rst_n low mid-run → outputs return to reset values next edge-free, no done.
- MHD_GEN_ABORT_EN: abort after 5 accepted words of k=4 → out_valid low next cycle, done pulse, count=5.

Source files
------------

// File: rtl/mhd_pkg.sv
// Shared types and helpers for the Hamming-distance pattern generator.
package mhd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        HOLD,
        FIN
    } state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int unsigned popcount(input logic [15:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/mhd_pattern_gen_if.sv
// Output handshake bundle of the pattern generator.
interface mhd_pattern_gen_if #(
    parameter int WIDTH = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [WIDTH-1:0] out_mask;

    modport master (
        output out_valid,
        output out_word,
        output out_mask,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_word,
        input  out_mask,
        output out_ready
    );
endinterface

// File: rtl/mhd_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module mhd_popcount
    import mhd_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    localparam int PW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [PW-1:0]    cnt
);
    assign cnt = PW'(popcount(16'(vec)));
endmodule

// File: rtl/mhd_pattern_gen.sv
// Enumerates every word at Hamming distance k from base, masks ascending.
// Optional abort input enabled by defining MHD_GEN_ABORT_EN.
module mhd_pattern_gen
    import mhd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = 4,
    parameter int CW    = WIDTH + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [KW-1:0]    k,
`ifdef MHD_GEN_ABORT_EN
    input  logic             abort,
`endif
    mhd_pattern_gen_if.master o,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] base_q, base_n;
    logic [KW-1:0]    k_q, k_n;
    logic [WIDTH-1:0] cand, cand_n;
    logic             vld_n;
    logic [WIDTH-1:0] word_n, mask_n;
    logic [CW-1:0]    cnt_n;
    logic             busy_n, done_n;
    logic [PW-1:0]    pc;
    logic             hit, last, abort_hit;

    mhd_popcount #(.WIDTH(WIDTH)) u_pc (
        .vec(cand),
        .cnt(pc)
    );

    assign hit  = (KW'(pc) == k_q);
    assign last = &cand;

`ifdef MHD_GEN_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        base_n  = base_q;
        k_n     = k_q;
        cand_n  = cand;
        vld_n   = o.out_valid;
        word_n  = o.out_word;
        mask_n  = o.out_mask;
        cnt_n   = count;
        unique case (state)
            IDLE: begin
                if (start) begin
                    base_n  = base;
                    k_n     = k;
                    cand_n  = '0;
                    cnt_n   = '0;
                    state_n = (k > KW'(WIDTH)) ? FIN : SCAN;
                end
            end
            SCAN: begin
                if (abort_hit) begin
                    state_n = FIN;
                end else if (hit) begin
                    mask_n  = cand;
                    word_n  = base_q ^ cand;
                    vld_n   = 1'b1;
                    state_n = HOLD;
                end else if (last) begin
                    state_n = FIN;
                end else begin
                    cand_n = cand + WIDTH'(1);
                end
            end
            HOLD: begin
                // abort wins over a same-cycle handshake
                if (abort_hit) begin
                    vld_n   = 1'b0;
                    state_n = FIN;
                end else if (o.out_ready) begin
                    cnt_n = count + CW'(1);
                    vld_n = 1'b0;
                    if (last) begin
                        state_n = FIN;
                    end else begin
                        cand_n  = cand + WIDTH'(1);
                        state_n = SCAN;
                    end
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        busy_n = (state_n == SCAN) || (state_n == HOLD);
        done_n = (state_n == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            base_q      <= '0;
            k_q         <= '0;
            cand        <= '0;
            o.out_valid <= 1'b0;
            o.out_word  <= '0;
            o.out_mask  <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            base_q      <= base_n;
            k_q         <= k_n;
            cand        <= cand_n;
            o.out_valid <= vld_n;
            o.out_word  <= word_n;
            o.out_mask  <= mask_n;
            count       <= cnt_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end
endmodule

// File: tb/tb_mhd_pattern_gen.sv
// Bench for mhd_pattern_gen: table vectors, random runs vs enumeration model.
module tb_mhd_pattern_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] base = '0;
    logic [3:0] k = '0;
    logic       abort = 1'b0;
    logic       busy, done;
    logic [8:0] count;

    int checks = 0;
    int failures = 0;

    logic [7:0] got_w[$];
    logic [7:0] got_m[$];
    int first_v, done_c;

    mhd_pattern_gen_if #(.WIDTH(8)) bus ();

    mhd_pattern_gen #(.WIDTH(8), .KW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .base  (base),
        .k     (k),
`ifdef MHD_GEN_ABORT_EN
        .abort (abort),
`endif
        .o     (bus.master),
        .busy  (busy),
        .done  (done),
        .count (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one enumeration; inj >= 0 pulses a stray start at that cycle.
    task automatic run(input logic [7:0] b, input logic [3:0] kk,
                       input int pct, input int inj);
        logic [7:0] em[$];
        logic [7:0] mm, pw, pm;
        logic pv, pr;
        bit fin;
        int cyc, n;
        em = {};
        for (int m = 0; m < 256; m++) begin
            mm = 8'(m);
            if ($countones(mm) == int'(kk)) em.push_back(mm);
        end
        got_w = {};
        got_m = {};
        first_v = -1;
        done_c = -1;
        base = b;
        k = kk;
        start = 1'b1;
        step();
        start = 1'b0;
        pv = 1'b0;
        pr = 1'b0;
        pw = '0;
        pm = '0;
        fin = 1'b0;
        cyc = 0;
        while (!fin && cyc < 3000) begin
            if (pv && !pr) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_word", 32'(bus.out_word), 32'(pw));
                chk("hold_mask", 32'(bus.out_mask), 32'(pm));
            end
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (done) begin
                done_c = cyc;
                fin = 1'b1;
            end else begin
                chk("busy_run", 32'(busy), 1);
            end
            start = (cyc == inj);
            if (cyc == inj) begin
                base = 8'hFF;
                k = 4'd1;
            end
            bus.out_ready = ($urandom_range(99) < pct);
            if (bus.out_valid && bus.out_ready) begin
                got_w.push_back(bus.out_word);
                got_m.push_back(bus.out_mask);
            end
            pv = bus.out_valid;
            pr = bus.out_ready;
            pw = bus.out_word;
            pm = bus.out_mask;
            if (!fin) begin
                step();
                cyc++;
            end
        end
        start = 1'b0;
        bus.out_ready = 1'b0;
        if (!fin) chk("timeout", 0, 1);
        chk("n_words", got_w.size(), em.size());
        chk("count", 32'(count), em.size());
        n = (got_w.size() < em.size()) ? got_w.size() : em.size();
        for (int i = 0; i < n; i++) begin
            chk("word", 32'(got_w[i]), 32'(b ^ em[i]));
            chk("mask", 32'(got_m[i]), 32'(em[i]));
        end
        step();
        chk("done_once", 32'(done), 0);
        chk("busy_after", 32'(busy), 0);
        chk("count_hold", 32'(count), em.size());
    endtask

    typedef struct {
        logic [7:0] base;
        logic [3:0] k;
        int         pct;
        int         n;
        logic [7:0] first;
        logic [7:0] last;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bus.out_ready = 1'b0;
        tbl[0] = '{8'h00, 4'd2, 100, 28, 8'h03, 8'hC0};
        tbl[1] = '{8'hA5, 4'd0, 100, 1, 8'h00, 8'h00};
        tbl[2] = '{8'hA5, 4'd8, 100, 1, 8'hFF, 8'hFF};
        tbl[3] = '{8'hA5, 4'd9, 100, 0, 8'h00, 8'h00};
        tbl[4] = '{8'h0F, 4'd1, 50, 8, 8'h01, 8'h80};

        #3;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_word", 32'(bus.out_word), 0);
        chk("rst_mask", 32'(bus.out_mask), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_count", 32'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 5; t++) begin
            run(tbl[t].base, tbl[t].k, tbl[t].pct, -1);
            chk("tbl_n", got_m.size(), tbl[t].n);
            if (tbl[t].n > 0 && got_m.size() > 0) begin
                chk("tbl_first", 32'(got_m[0]), 32'(tbl[t].first));
                chk("tbl_last", 32'(got_m[got_m.size()-1]),
                    32'(tbl[t].last));
                // one candidate per cycle from 0, so first hit at mask+1
                chk("tbl_lat", first_v, int'(tbl[t].first) + 1);
            end else begin
                chk("tbl_nodone_lat", done_c, 0);
                chk("tbl_novalid", first_v, -1);
            end
        end
        if (got_w.size() > 1) chk("second_mask_0f", 32'(got_m[1]), 32'h02);

        run(8'h00, 4'd3, 100, 10);
        chk("inj_n", got_w.size(), 56);

        for (int r = 0; r < 8; r++) begin
            run(8'($urandom), 4'($urandom_range(0, 9)),
                $urandom_range(30, 100), -1);
        end

        base = 8'h00;
        k = 4'd3;
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 20; i++) step();
        rst_n = 1'b0;
        #2;
        chk("mrst_valid", 32'(bus.out_valid), 0);
        chk("mrst_word", 32'(bus.out_word), 0);
        chk("mrst_mask", 32'(bus.out_mask), 0);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_count", 32'(count), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mrst_nodone", 32'(done), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mrst_idle", 32'(busy), 0);
        chk("mrst_done2", 32'(done), 0);

`ifdef MHD_GEN_ABORT_EN
        begin
            int acc, cyc;
            bit ok;
            acc = 0;
            cyc = 0;
            base = 8'h00;
            k = 4'd4;
            bus.out_ready = 1'b1;
            start = 1'b1;
            step();
            start = 1'b0;
            while (acc < 5 && cyc < 2000) begin
                if (bus.out_valid) acc++;
                step();
                cyc++;
            end
            ok = 1'b0;
            while (!ok && cyc < 2000) begin
                if (bus.out_valid) ok = 1'b1;
                else begin
                    step();
                    cyc++;
                end
            end
            if (!ok) chk("abort_timeout", 0, 1);
            abort = 1'b1;
            step();
            abort = 1'b0;
            bus.out_ready = 1'b0;
            chk("abort_valid", 32'(bus.out_valid), 0);
            chk("abort_done", 32'(done), 1);
            chk("abort_count", 32'(count), 5);
            step();
            chk("abort_done_once", 32'(done), 0);
            chk("abort_busy", 32'(busy), 0);
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("abort_idle_ignored", 32'(done), 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
